// File: rtl/bfly_pkg.sv
// bfly_pkg: shared defaults, sample type and FSM state for the butterfly pair feeder.
package bfly_pkg;
    localparam int N_D = 16;
    localparam int IN_BIT_D = 14;
    localparam int IDX_W_D = 8;
    typedef logic signed [IN_BIT_D-1:0] sample_t;
    typedef enum logic {FILL_A, FILL_B} state_t;
endpackage

// File: rtl/bfly_pair_feeder_if.sv
// bfly_pair_feeder_if: block input / pair output bundle; flush exists only with BFLY_FEED_FLUSH_EN.
interface bfly_pair_feeder_if #(
    parameter int N = bfly_pkg::N_D,
    parameter int IN_BIT = bfly_pkg::IN_BIT_D,
    parameter int IDX_W = bfly_pkg::IDX_W_D
);
    logic s_valid, s_ready, m_valid, m_ready;
    logic signed [IN_BIT-1:0] s_i [N];
    logic signed [IN_BIT-1:0] s_q [N];
    logic signed [IN_BIT-1:0] d1_i [N];
    logic signed [IN_BIT-1:0] d1_q [N];
    logic signed [IN_BIT-1:0] d2_i [N];
    logic signed [IN_BIT-1:0] d2_q [N];
    logic [IDX_W-1:0] m_idx;
`ifdef BFLY_FEED_FLUSH_EN
    logic flush;
`endif
    modport slave (
        input s_valid, s_i, s_q, m_ready,
`ifdef BFLY_FEED_FLUSH_EN
        input flush,
`endif
        output s_ready, m_valid, d1_i, d1_q, d2_i, d2_q, m_idx
    );
    modport master (
        output s_valid, s_i, s_q, m_ready,
`ifdef BFLY_FEED_FLUSH_EN
        output flush,
`endif
        input s_ready, m_valid, d1_i, d1_q, d2_i, d2_q, m_idx
    );
endinterface

// File: rtl/bfly_lane_reg.sv
// bfly_lane_reg: N-lane I/Q register with load enable and synchronous clear.
module bfly_lane_reg import bfly_pkg::*; #(
    parameter int N = N_D,
    parameter int W = IN_BIT_D
) (
    input  logic clk,
    input  logic clr,
    input  logic ld,
    input  logic signed [W-1:0] d_i [N],
    input  logic signed [W-1:0] d_q [N],
    output logic signed [W-1:0] q_i [N],
    output logic signed [W-1:0] q_q [N]
);
    always_ff @(posedge clk)
        for (int k = 0; k < N; k++) begin
            q_i[k] <= clr ? '0 : ld ? d_i[k] : q_i[k];
            q_q[k] <= clr ? '0 : ld ? d_q[k] : q_q[k];
        end
endmodule

// File: rtl/bfly_pair_feeder.sv
// bfly_pair_feeder: pairs consecutive I/Q blocks into butterfly operands d1/d2 with a running pair index.
// Optional flush of a half-built pair is compiled in with BFLY_FEED_FLUSH_EN.
module bfly_pair_feeder import bfly_pkg::*; #(
    parameter int N = N_D,
    parameter int IN_BIT = IN_BIT_D,
    parameter int IDX_W = IDX_W_D
) (
    input logic clk,
    input logic rstn,
    bfly_pair_feeder_if.slave bus
);
    state_t state, state_nxt;
    logic fl, rdy, acc, ld_a, ld_o, vld;
    logic [IDX_W-1:0] idx;
    logic signed [IN_BIT-1:0] a_i [N];
    logic signed [IN_BIT-1:0] a_q [N];
`ifdef BFLY_FEED_FLUSH_EN
    assign fl = bus.flush;
`else
    assign fl = 1'b0;
`endif
    always_ff @(posedge clk)
        state <= rstn ? FILL_A : state_nxt;
    always_comb
        state_nxt = acc ? (state == FILL_A ? FILL_B : FILL_A) : fl ? FILL_A : state;
    // flush blocks acceptance, so it always wins over a simultaneous s_valid
    always_comb begin
        rdy = !rstn && !fl && (state == FILL_A || !vld || bus.m_ready);
        acc = bus.s_valid && rdy;
        ld_a = acc && state == FILL_A;
        ld_o = acc && state == FILL_B;
    end
    always_ff @(posedge clk) begin
        vld <= !rstn && (ld_o || (vld && !bus.m_ready));
        idx <= rstn ? '0 : (vld && bus.m_ready) ? idx + 1'b1 : idx;
    end
    assign bus.s_ready = rdy;
    assign bus.m_valid = vld;
    assign bus.m_idx = idx;
    bfly_lane_reg #(.N(N), .W(IN_BIT)) u_half_a (
        .clk(clk), .clr(rstn), .ld(ld_a),
        .d_i(bus.s_i), .d_q(bus.s_q), .q_i(a_i), .q_q(a_q)
    );
    bfly_lane_reg #(.N(N), .W(IN_BIT)) u_out_d1 (
        .clk(clk), .clr(rstn), .ld(ld_o),
        .d_i(a_i), .d_q(a_q), .q_i(bus.d1_i), .q_q(bus.d1_q)
    );
    bfly_lane_reg #(.N(N), .W(IN_BIT)) u_out_d2 (
        .clk(clk), .clr(rstn), .ld(ld_o),
        .d_i(bus.s_i), .d_q(bus.s_q), .q_i(bus.d2_i), .q_q(bus.d2_q)
    );
endmodule

// File: doc/bfly_pair_feeder.md
BFLY_PAIR_FEEDER -- requirements
Module: bfly_pair_feeder

Interface
REQ-001 SHALL have parameter N, default 16, lanes per block.
REQ-002 SHALL have parameter IN_BIT, default 14, signed sample width.
REQ-003 SHALL have parameter IDX_W, default 8, pair index width.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, synchronous and active-high (asserted = 1, despite the name).
REQ-006 SHALL have port s_valid  in  1  input block valid.
REQ-007 SHALL have port s_ready  out  1  input block accepted when s_valid && s_ready.
REQ-008 SHALL have ports s_i, s_q  in  N x IN_BIT signed  input block I/Q lanes.
REQ-009 SHALL have port m_valid  out  1  output pair valid.
REQ-010 SHALL have port m_ready  in  1  downstream butterfly accepts pair.
REQ-011 SHALL have ports d1_i, d1_q, d2_i, d2_q  out  N x IN_BIT signed  pair operands for the butterfly.
REQ-012 SHALL have port m_idx  out  IDX_W  index of the pair on the output.
REQ-013 SHALL have port flush  in  1  discard a half-built pair (present only with BFLY_FEED_FLUSH_EN).

Function
REQ-014 SHALL run a two-state FSM: FILL_A (expects first block) and FILL_B (expects second block).
REQ-015 SHALL, on an accept in FILL_A, store the block in the half-A register and go to FILL_B.
REQ-016 SHALL, on an accept in FILL_B, load d1 from the half-A register and d2 from s_i/s_q into the output register, set m_valid, and return to FILL_A.
REQ-017 SHALL drive s_ready=1 in FILL_A and s_ready=(!m_valid || m_ready) in FILL_B.
REQ-018 SHALL clear m_valid on m_valid && m_ready unless a new pair loads in the same cycle, in which case m_valid stays 1.
REQ-019 SHALL hold d1/d2/m_idx stable while m_valid && !m_ready.
REQ-020 SHALL have a latency of one cycle from the second-block accept to m_valid=1.
REQ-021 SHALL sustain one pair every two cycles with s_valid and m_ready held at 1.
REQ-022 SHALL increment m_idx by 1 modulo 2^IDX_W on each output handshake, wrapping from 2^IDX_W-1 to 0.
REQ-023 SHALL pass samples bit-exact with no arithmetic or width change.
REQ-024 SHALL accept a FILL_A block while a previous pair is still stalled on the output.

Reset
REQ-025 SHALL, while rstn=1, force FILL_A, m_valid=0, m_idx=0, and d1/d2/half-A to 0; s_ready SHALL be 0 during reset.
REQ-026 SHALL, when reset is asserted mid-pair or mid-stall, discard all buffered data, and the next accepted block SHALL be a first half.

Configuration
REQ-027 SHALL compile the flush port and logic only when BFLY_FEED_FLUSH_EN is defined.
REQ-028 SHALL, with BFLY_FEED_FLUSH_EN defined, return from FILL_B to FILL_A when flush=1 with no accept; flush SHALL force s_ready=0, so flush wins over a simultaneous s_valid, and it SHALL leave the output register untouched.
REQ-029 SHALL, without BFLY_FEED_FLUSH_EN, have no flush port and FSM behaviour identical to flush=0.

Structure
REQ-030 SHALL place in shared package bfly_pkg: the default constants for N, IN_BIT and IDX_W, the signed sample typedef, and the FSM state enum (FILL_A, FILL_B).
REQ-031 SHALL use one sub-module, bfly_lane_reg (N-lane I/Q register with load enable and sync clear), instantiated for half-A and for the output pair.

Verification
REQ-032 SHALL cover this scenario: after reset, send block0 lanes I=k, Q=-k, then block1 lanes I=100+k, with m_ready=1 -> one cycle later m_valid=1, d1_i[k]=k, d2_i[k]=100+k, m_idx=0.
REQ-033 SHALL cover this scenario: s_valid=1 and m_ready=1 continuously for 8 blocks -> 4 pairs on alternate cycles, m_idx=0,1,2,3.
REQ-034 SHALL cover this scenario: m_ready=0 after the first pair, then 3 more blocks offered -> block A accepted, s_ready=0 in FILL_B, outputs stable; raising m_ready completes pair 1 on the next accept.
REQ-035 SHALL cover this scenario: boundary values -8192 and 8191 in all lanes -> outputs bit-exact, and m_idx wraps 255 -> 0 on the 257th pair.
REQ-036 SHALL cover this scenario: rstn=1 pulsed while in FILL_B with a stalled pair -> m_valid=0, m_idx=0, and the next block is treated as half A.
REQ-037 SHALL cover this scenario: with BFLY_FEED_FLUSH_EN, flush=1 and s_valid=1 together in FILL_B -> block not accepted, state becomes FILL_A, and the pending output pair is unaffected.
